// File: rtl/ijtag_sib_access_sequencer.sv
// ijtag_sib_access_sequencer: opens a SIB if needed, scans {SIB + host TDR}, returns the captured bits
// and optionally leaves the SIB closed. Control outputs are flopped from the current state.
module ijtag_sib_access_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W = 6
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ltest_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_close,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              sib_open,
    output logic              ijtag_sel,
    output logic              ijtag_ce,
    output logic              ijtag_se,
    output logic              ijtag_ue,
    output logic              ijtag_si,
    input  logic              ijtag_so
);
    typedef enum logic [3:0] {IDLE, O_CAP, O_SHIFT, O_UPD, WAIT, CAP, SHIFT, UPD, DONE} state_t;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
    state_t state;
    logic [LEN_W-1:0] len_q, k;
    logic [DATA_W-1:0] data_q, cap_mask;
    logic close_q, err_q, cap_en;
    assign req_ready = state == IDLE && !ltest_en && !ijtag_reset;
    assign busy = state != IDLE;
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            state <= IDLE;
            len_q <= '0;
            k <= '0;
            data_q <= '0;
            cap_mask <= '0;
            close_q <= 1'b0;
            err_q <= 1'b0;
            cap_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            sib_open <= 1'b0;
            ijtag_sel <= 1'b0;
            ijtag_ce <= 1'b0;
            ijtag_se <= 1'b0;
            ijtag_ue <= 1'b0;
            ijtag_si <= 1'b0;
        end else begin
            ijtag_sel <= state != IDLE;
            ijtag_ce <= 1'b0;
            ijtag_se <= 1'b0;
            ijtag_ue <= 1'b0;
            ijtag_si <= 1'b0;
            rsp_valid <= 1'b0;
            cap_en <= 1'b0;
            // so is sampled one cycle behind the shift state, matching the registered se/si
            if (cap_en) begin
                rsp_data <= rsp_data | (ijtag_so ? cap_mask : '0);
                cap_mask <= cap_mask << 1;
            end
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    state <= sib_open ? CAP : O_CAP;
                    len_q <= req_len > MAX_LEN ? MAX_LEN : req_len;
                    err_q <= req_len > MAX_LEN;
                    data_q <= req_data;
                    close_q <= req_close;
                    k <= '0;
                    cap_mask <= DATA_W'(1);
                    rsp_data <= '0;
                    rsp_err <= 1'b0;
                end
                O_CAP: begin
                    ijtag_ce <= 1'b1;
                    state <= O_SHIFT;
                end
                O_SHIFT: begin
                    ijtag_se <= 1'b1;
                    ijtag_si <= 1'b1;
                    state <= O_UPD;
                end
                O_UPD: begin
                    ijtag_ue <= 1'b1;
                    sib_open <= 1'b1;
                    state <= WAIT;
                end
                WAIT: state <= CAP;
                CAP: begin
                    ijtag_ce <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    ijtag_se <= 1'b1;
                    ijtag_si <= k == '0 ? ~close_q : data_q[0];
                    cap_en <= k != '0;
                    if (k != '0) data_q <= data_q >> 1;
                    if (k == len_q) state <= UPD;
                    else k <= k + LEN_W'(1);
                end
                UPD: begin
                    ijtag_ue <= 1'b1;
                    sib_open <= ~close_q;
                    state <= DONE;
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_err <= err_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ijtag_sib_access_sequencer.sv
// tb_ijtag_sib_access_sequencer: directed scenarios against a behavioural SIB + host TDR target.
module tb_ijtag_sib_access_sequencer;
    logic ijtag_tck = 1'b0, ijtag_reset = 1'b1, ltest_en = 1'b0;
    logic req_valid = 1'b0, req_close = 1'b0;
    logic [5:0] req_len = '0;
    logic [31:0] req_data = '0;
    logic req_ready, rsp_valid, rsp_err, busy, sib_open;
    logic [31:0] rsp_data;
    logic ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;
    int tests = 0, fails = 0;
    int lat, se_cnt, ce_cnt, ue_cnt, tgt_len;
    logic [63:0] si_log;
    logic [10:0] rst_snap;
    logic acc_ok;
    logic sib_sr, sib_upd;
    logic [31:0] tdr_sr, tdr_cap = '0, tdr_upd;

    ijtag_sib_access_sequencer #(.DATA_W(32), .LEN_W(6)) dut (
        .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .ltest_en(ltest_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_data(req_data),
        .req_close(req_close), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .sib_open(sib_open), .ijtag_sel(ijtag_sel), .ijtag_ce(ijtag_ce),
        .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue), .ijtag_si(ijtag_si), .ijtag_so(ijtag_so)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    function automatic logic [31:0] shin(logic [31:0] v, logic b, int n);
        logic [31:0] r;
        r = v >> 1;
        r[n-1] = b;
        return r;
    endfunction

    // Target: si -> TDR[len-1] .. TDR[0] -> SIB -> so when open, si -> SIB -> so when closed
    assign ijtag_so = sib_sr;
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sib_sr <= 1'b0;
            tdr_sr <= '0;
        end else if (ijtag_sel && ijtag_ce) begin
            sib_sr <= 1'b0;
            tdr_sr <= tdr_cap;
        end else if (ijtag_sel && ijtag_se) begin
            if (sib_upd && tgt_len > 0) begin
                sib_sr <= tdr_sr[0];
                tdr_sr <= shin(tdr_sr, ijtag_si, tgt_len);
            end else sib_sr <= ijtag_si;
        end
    end
    always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sib_upd <= 1'b0;
            tdr_upd <= '0;
        end else if (ijtag_sel && ijtag_ue) begin
            sib_upd <= sib_sr;
            if (sib_upd) tdr_upd <= tdr_sr;
        end
    end

    function automatic logic [10:0] outs();
        return {req_ready, rsp_valid, rsp_err, busy, sib_open, ijtag_sel, ijtag_ce, ijtag_se,
                ijtag_ue, ijtag_si, |rsp_data};
    endfunction

    task automatic run_req(input int len, input logic [31:0] data, input logic cl,
                           input int ltest_at, input int rst_at, input int budget);
        @(negedge ijtag_tck);
        req_valid = 1'b1;
        req_len = 6'(len);
        req_data = data;
        req_close = cl;
        tgt_len = len > 32 ? 32 : len;
        #1 acc_ok = req_ready;
        @(posedge ijtag_tck);
        #1 req_valid = 1'b0;
        lat = 0; se_cnt = 0; ce_cnt = 0; ue_cnt = 0; si_log = '0; rst_snap = '1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge ijtag_tck);
            if (c == ltest_at) ltest_en = 1'b1;
            if (c == rst_at) begin
                ijtag_reset = 1'b1;
                #1 rst_snap = outs();
            end
            if (ijtag_se) begin
                si_log[se_cnt] = ijtag_si;
                se_cnt++;
            end
            if (ijtag_ce) ce_cnt++;
            if (ijtag_ue) ue_cnt++;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ijtag_tck);
        tests++; if (outs() !== 11'b0) begin fails++; $display("FAIL reset_outs: got %b want 0", outs()); end
        ijtag_reset = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_open_access();
        tdr_cap = 32'h3C;
        run_req(8, 32'hA5, 1'b0, 0, 0, 40);
        tests++; if (acc_ok !== 1'b1) begin fails++; $display("FAIL open_acc: got %b want 1", acc_ok); end
        tests++; if (lat != 17) begin fails++; $display("FAIL open_lat: got %0d want 17", lat); end
        tests++; if (ce_cnt != 2 || ue_cnt != 2 || se_cnt != 10) begin fails++; $display("FAIL open_pulses: got ce=%0d ue=%0d se=%0d want 2 2 10", ce_cnt, ue_cnt, se_cnt); end
        tests++; if (si_log[9:0] !== 10'h297) begin fails++; $display("FAIL open_si: got %h want 297", si_log[9:0]); end
        tests++; if (rsp_data !== 32'h3C || rsp_err !== 1'b0) begin fails++; $display("FAIL open_rsp: got %h/%b want 3c/0", rsp_data, rsp_err); end
        tests++; if (sib_open !== 1'b1 || sib_upd !== 1'b1) begin fails++; $display("FAIL open_sib: got %b/%b want 1/1", sib_open, sib_upd); end
        tests++; if (tdr_upd !== 32'hA5) begin fails++; $display("FAIL open_tdr: got %h want a5", tdr_upd); end
    endtask

    task automatic test_open_sib_close();
        tdr_cap = 32'h9;
        run_req(4, 32'h3, 1'b1, 0, 0, 40);
        tests++; if (lat != 9) begin fails++; $display("FAIL close_lat: got %0d want 9", lat); end
        tests++; if (ce_cnt != 1 || ue_cnt != 1 || se_cnt != 5) begin fails++; $display("FAIL close_pulses: got ce=%0d ue=%0d se=%0d want 1 1 5", ce_cnt, ue_cnt, se_cnt); end
        tests++; if (si_log[4:0] !== 5'b00110) begin fails++; $display("FAIL close_si: got %b want 00110", si_log[4:0]); end
        tests++; if (rsp_data !== 32'h9) begin fails++; $display("FAIL close_data: got %h want 9", rsp_data); end
        tests++; if (sib_open !== 1'b0 || sib_upd !== 1'b0 || tdr_upd !== 32'h3) begin fails++; $display("FAIL close_sib: got %b/%b/%h want 0/0/3", sib_open, sib_upd, tdr_upd); end
    endtask

    task automatic test_saturate();
        tdr_cap = 32'h12345678;
        run_req(40, 32'hDEADBEEF, 1'b0, 0, 0, 60);
        tests++; if (lat != 41) begin fails++; $display("FAIL sat_lat: got %0d want 41", lat); end
        tests++; if (se_cnt != 34) begin fails++; $display("FAIL sat_se: got %0d want 34", se_cnt); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL sat_err: got %b want 1", rsp_err); end
        tests++; if (rsp_data !== 32'h12345678 || tdr_upd !== 32'hDEADBEEF) begin fails++; $display("FAIL sat_data: got %h/%h want 12345678/deadbeef", rsp_data, tdr_upd); end
    endtask

    task automatic test_len0();
        run_req(0, 32'hFFFF, 1'b1, 0, 0, 20);
        tests++; if (lat != 5) begin fails++; $display("FAIL len0_lat: got %0d want 5", lat); end
        tests++; if (se_cnt != 1 || si_log[0] !== 1'b0) begin fails++; $display("FAIL len0_shift: got se=%0d si=%b want 1 0", se_cnt, si_log[0]); end
        tests++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL len0_rsp: got %h/%b want 0/0", rsp_data, rsp_err); end
        tests++; if (sib_open !== 1'b0 || sib_upd !== 1'b0) begin fails++; $display("FAIL len0_sib: got %b/%b want 0/0", sib_open, sib_upd); end
    endtask

    task automatic test_ltest();
        logic bad;
        bad = 1'b0;
        @(negedge ijtag_tck);
        ltest_en = 1'b1;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge ijtag_tck);
            if (req_ready !== 1'b0 || busy !== 1'b0 || ijtag_sel !== 1'b0) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL ltest_idle: got stray activity %b want 0", bad); end
        ltest_en = 1'b0;
        req_valid = 1'b0;
        tdr_cap = 32'hA;
        run_req(4, 32'h5, 1'b0, 8, 0, 40);
        tests++; if (lat != 13 || rsp_data !== 32'hA) begin fails++; $display("FAIL ltest_mid: got lat=%0d data=%h want 13 a", lat, rsp_data); end
        bad = 1'b0;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge ijtag_tck);
            if (req_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL ltest_hold: got accept/busy %b want 0", bad); end
        ltest_en = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_req(8, 32'hFF, 1'b0, 0, 5, 12);
        tests++; if (rst_snap !== 11'b0) begin fails++; $display("FAIL rstmid_outs: got %b want 0", rst_snap); end
        tests++; if (lat != 0) begin fails++; $display("FAIL rstmid_rsp: got rsp_valid at %0d want none", lat); end
        @(negedge ijtag_tck);
        ijtag_reset = 1'b0;
        tdr_cap = 32'h77;
        run_req(8, 32'h5A, 1'b1, 0, 0, 40);
        tests++; if (lat != 17 || ce_cnt != 2) begin fails++; $display("FAIL rstmid_reopen: got lat=%0d ce=%0d want 17 2", lat, ce_cnt); end
        tests++; if (rsp_data !== 32'h77 || sib_open !== 1'b0) begin fails++; $display("FAIL rstmid_rsp2: got %h/%b want 77/0", rsp_data, sib_open); end
    endtask

    initial begin
        test_reset();
        test_open_access();
        test_open_sib_close();
        test_saturate();
        test_len0();
        test_ltest();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
